shift_reg: RTL and testbench

SHIFT_REG -- requirements
Module: shift_reg

---
 rtl/shift_reg_pkg.sv | 14 +
 rtl/shift_reg_next.sv | 25 ++
 rtl/shift_reg.sv | 51 +++++
 tb/tb_shift_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the shift register: operation-select encoding and reset value.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_LEFT  = 2'd2,
        MODE_RIGHT = 2'd3
    } mode_e;

    // Replicated to the register width by users of the package.
    localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/shift_reg_next.sv
// Next-state logic for shift_reg: hold, parallel load, or shift left/right by one bit.
module shift_reg_next
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p_cur,
    input  logic             d,
    input  logic [WIDTH-1:0] par,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] p_next
);

    // Unknown or unlisted mode codes fall through to hold.
    always_comb begin
        p_next = p_cur;
        case (mode)
            MODE_LOAD:  p_next = par;
            MODE_LEFT:  p_next = {p_cur[WIDTH-2:0], d};
            MODE_RIGHT: p_next = {d, p_cur[WIDTH-1:1]};
            default:    p_next = p_cur;
        endcase
    end

endmodule

// File: rtl/shift_reg.sv
// Universal shift register: state register plus next-state instance.
// Define SHIFT_REG_SER_OUT_EN to add the serial output Q.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             D,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] par_i,
`ifdef SHIFT_REG_SER_OUT_EN
    output logic             Q,
`endif
    output logic [WIDTH-1:0] P
);

    logic [WIDTH-1:0] p_next;

    shift_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .p_cur  (P),
        .d      (D),
        .par    (par_i),
        .mode   (mode_i),
        .p_next (p_next)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            P <= {WIDTH{RST_BIT}};
        end else begin
            P <= p_next;
        end
    end

`ifdef SHIFT_REG_SER_OUT_EN
    // Bit about to fall off the end in the current shift direction; P is zero in reset.
    always_comb begin
        Q = 1'b0;
        case (mode_i)
            MODE_LEFT:  Q = P[WIDTH-1];
            MODE_RIGHT: Q = P[0];
            default:    Q = 1'b0;
        endcase
    end
`endif

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboard bench for shift_reg: stimulus pushes hand-computed P values, a negedge monitor checks them.
module tb_shift_reg;
    import shift_reg_pkg::*;

    localparam int W = 8;

    logic         tb_clk;
    logic         nrst;
    logic         D;
    logic [1:0]   mode_i;
    logic [W-1:0] par_i;
    logic [W-1:0] P;
`ifdef SHIFT_REG_SER_OUT_EN
    logic         Q;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    shift_reg #(.WIDTH(W)) dut (
        .clk    (tb_clk),
        .nrst   (nrst),
        .D      (D),
        .mode_i (mode_i),
        .par_i  (par_i),
`ifdef SHIFT_REG_SER_OUT_EN
        .Q      (Q),
`endif
        .P      (P)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Monitor: one expected P per clock edge, compared on the following falling edge.
    always @(negedge tb_clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (P !== e) begin
                n_fail++;
                $display("FAIL scoreboard_p: P=%h expected=%h at %0t", P, e, $time);
            end
`ifdef SHIFT_REG_SER_OUT_EN
            begin
                logic eq;
                eq = (mode_i == MODE_LEFT) ? e[W-1] : (mode_i == MODE_RIGHT) ? e[0] : 1'b0;
                n_checks++;
                if (Q !== eq) begin
                    n_fail++;
                    $display("FAIL scoreboard_q: Q=%b expected=%b at %0t", Q, eq, $time);
                end
            end
`endif
        end
    end

    task automatic check_now(input string name, input logic [W-1:0] e);
        n_checks++;
        if (P !== e) begin
            n_fail++;
            $display("FAIL %s: P=%h expected=%h at %0t", name, P, e, $time);
        end
    endtask

    // Caller is one time unit past a falling edge; returns at the same point a cycle later.
    task automatic step(input logic [1:0] m, input logic d, input logic [W-1:0] par,
                        input logic [W-1:0] e);
        mode_i = m;
        D      = d;
        par_i  = par;
        @(posedge tb_clk);
        #1;
        exp_q.push_back(e);
        @(negedge tb_clk);
        #1;
    endtask

    task automatic shift_seq(input logic [1:0] m, input int n, input logic [15:0] bits,
                             input logic [W-1:0] exps[16]);
        for (int i = 0; i < n; i++) begin
            step(m, bits[i], 8'h00, exps[i]);
        end
    endtask

    logic [W-1:0] left_exp[16]  = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2A, 8'h55, 8'hAA,
                                    8'h55, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [W-1:0] right_exp[16] = '{8'h80, 8'h40, 8'hA0, 8'h50, 8'hA8, 8'h54, 8'hAA, 8'h55,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [W-1:0] mid_exp[16]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        // bits are applied LSB-first: index i is the i-th bit shifted in
        logic [15:0] pat_left10;
        logic [15:0] pat_alt;
        logic [15:0] pat_ones;
        int          waited;
        pat_left10 = 16'b0000_0011_0101_0101;
        pat_alt    = 16'b0000_0000_0101_0101;
        pat_ones   = 16'b0000_0000_0000_1111;

        nrst   = 1'b0;
        mode_i = MODE_LOAD;
        par_i  = 8'h77;
        D      = 1'b1;
        #2;
        check_now("reset_immediate", 8'h00);
        repeat (2) begin
            @(posedge tb_clk);
            #1;
            check_now("reset_across_edge", 8'h00);
        end
        @(negedge tb_clk);
        #1;
        nrst = 1'b1;
        #1;
        check_now("after_release", 8'h00);

        step(MODE_HOLD, 1'b1, 8'h55, 8'h00);

        shift_seq(MODE_LEFT, 10, pat_left10, left_exp);

        step(MODE_LOAD, 1'b1, 8'h00, 8'h00);
        shift_seq(MODE_RIGHT, 8, pat_alt, right_exp);

        step(MODE_LOAD, 1'b1, 8'h00, 8'h00);
        shift_seq(MODE_RIGHT, 6, pat_alt, right_exp);

        step(MODE_LOAD, 1'b0, 8'hFF, 8'hFF);
        repeat (3) step(MODE_HOLD, 1'b0, 8'h00, 8'hFF);

        step(MODE_LOAD, 1'b0, 8'h3C, 8'h3C);
        step(MODE_LEFT, 1'b1, 8'h00, 8'h79);

        step(MODE_LOAD, 1'b0, 8'h00, 8'h00);
        shift_seq(MODE_LEFT, 4, pat_ones, mid_exp);
        #2;
        nrst = 1'b0;
        #1;
        check_now("async_reset_midshift", 8'h00);
        mode_i = MODE_LOAD;
        par_i  = 8'hA5;
        @(posedge tb_clk);
        #1;
        check_now("reset_holds_vs_load", 8'h00);
        mode_i = MODE_LEFT;
        @(posedge tb_clk);
        #1;
        check_now("reset_holds_vs_shift", 8'h00);
        @(negedge tb_clk);
        #1;
        nrst = 1'b1;
        step(MODE_RIGHT, 1'b1, 8'h00, 8'h80);

        waited = 0;
        while (exp_q.size() > 0 && waited < 4) begin
            @(negedge tb_clk);
            #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
